// File: rtl/tick_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tick_uart_tx
// Brief    : Async serial transmitter whose bit timing comes from an external
//            strobe; one start bit, DATA_W data bits LSB-first, STOP_BITS stops.
// Revision : 1.0 - initial release
// ============================================================================
module tick_uart_tx #(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int TICK_LEVEL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int              c_cnt_w     = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);
    localparam logic            c_stop_last = 1'(STOP_BITS - 1);
    localparam logic            c_tick_lvl  = 1'(TICK_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [DATA_W-1:0]    r_shreg;
    logic [DATA_W-1:0]    w_shreg_nx;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [c_cnt_w-1:0]   w_bit_cnt_nx;
    logic                 r_stop_cnt;
    logic                 w_stop_cnt_nx;
    logic                 r_tx;
    logic                 w_tx_nx;
    logic                 r_done;
    logic                 w_done_nx;
    logic                 w_strobe;

    assign w_strobe  = (tick == c_tick_lvl);
    assign ready_out = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign tx        = r_tx;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shreg    <= w_shreg_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_stop_cnt <= w_stop_cnt_nx;
            r_tx       <= w_tx_nx;
            r_done     <= w_done_nx;
        end
    end

    // Every transition except acceptance waits for a strobe; otherwise hold.
    always_comb begin
        w_state_nx    = r_state;
        w_shreg_nx    = r_shreg;
        w_bit_cnt_nx  = r_bit_cnt;
        w_stop_cnt_nx = r_stop_cnt;
        w_tx_nx       = r_tx;
        w_done_nx     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nx = 1'b1;
                if (valid_in) begin
                    w_state_nx    = S_ALIGN;
                    w_shreg_nx    = data_in;
                    w_bit_cnt_nx  = '0;
                    w_stop_cnt_nx = 1'b0;
                end
            end
            S_ALIGN: begin
                if (w_strobe) begin
                    w_state_nx = S_START;
                    w_tx_nx    = 1'b0;
                end
            end
            S_START: begin
                if (w_strobe) begin
                    w_state_nx   = S_DATA;
                    w_tx_nx      = r_shreg[0];
                    w_shreg_nx   = r_shreg >> 1;
                    w_bit_cnt_nx = '0;
                end
            end
            S_DATA: begin
                if (w_strobe) begin
                    if (r_bit_cnt == c_last_bit) begin
                        // Counter parks at its terminal value instead of wrapping.
                        w_state_nx    = S_STOP;
                        w_tx_nx       = 1'b1;
                        w_stop_cnt_nx = 1'b0;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + c_cnt_w'(1);
                        w_tx_nx      = r_shreg[0];
                        w_shreg_nx   = r_shreg >> 1;
                    end
                end
            end
            S_STOP: begin
                if (w_strobe) begin
                    if (r_stop_cnt == c_stop_last) begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_stop_cnt_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_uart_tx
// Brief    : Self-checking bench for tick_uart_tx (8/1 and 5/2 configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int phase    = 0;

    always #5 clk = ~clk;

    tick_uart_tx #(.DATA_W(8), .STOP_BITS(1), .TICK_LEVEL(0)) u_a (
        .clk(clk), .rst(rst), .tick(tick), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    tick_uart_tx #(.DATA_W(5), .STOP_BITS(2), .TICK_LEVEL(0)) u_b (
        .clk(clk), .rst(rst), .tick(tick), .data_in(data_in[4:0]), .valid_in(valid_in),
        .ready_out(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    // Reference model: a frame is a list of line levels, each started by one
    // strobe; the strobe after the list is exhausted ends the frame.
    int m_width [2] = '{8, 5};
    int m_stops [2] = '{1, 2};
    bit m_busy  [2];
    bit m_tx    [2];
    bit m_done  [2];
    bit q0[$];
    bit q1[$];

    task automatic model_edge(input int k);
        bit q[$];
        bit strobe;
        strobe = (tick == 1'b0);
        q = (k == 0) ? q0 : q1;
        if (rst) begin
            m_busy[k] = 1'b0;
            m_tx[k]   = 1'b1;
            m_done[k] = 1'b0;
            q.delete();
        end else begin
            m_done[k] = 1'b0;
            if (!m_busy[k]) begin
                if (valid_in) begin
                    m_busy[k] = 1'b1;
                    q.delete();
                    q.push_back(1'b0);
                    for (int i = 0; i < m_width[k]; i++) q.push_back(data_in[i]);
                    for (int s = 0; s < m_stops[k]; s++) q.push_back(1'b1);
                end
            end else if (strobe) begin
                if (q.size() > 0) begin
                    m_tx[k] = q.pop_front();
                end else begin
                    m_busy[k] = 1'b0;
                    m_done[k] = 1'b1;
                    m_tx[k]   = 1'b1;
                end
            end
        end
        if (k == 0) q0 = q; else q1 = q;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit t, input bit v, input logic [7:0] d);
        rst      = r;
        tick     = t;
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        cyc++;
        check("tx_a",    tx_a,    m_tx[0]);
        check("done_a",  done_a,  m_done[0]);
        check("ready_a", ready_a, !m_busy[0]);
        check("busy_a",  busy_a,  m_busy[0]);
        check("tx_b",    tx_b,    m_tx[1]);
        check("done_b",  done_b,  m_done[1]);
        check("ready_b", ready_b, !m_busy[1]);
        check("busy_b",  busy_b,  m_busy[1]);
    endtask

    function automatic bit strobe_now(input int p);
        return (phase % p) == (p - 1);
    endfunction

    task automatic step_p(input int p, input bit r, input bit v, input logic [7:0] d);
        bit t;
        t = strobe_now(p) ? 1'b0 : 1'b1;
        phase++;
        step(r, t, v, d);
    endtask

    task automatic run_until_idle(input int p, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            step_p(p, 1'b0, 1'b0, 8'h00);
            if (ready_a && ready_b) seen = 1'b1;
        end
        check({name, "_idle_timeout"}, seen, 1);
    endtask

    typedef struct {
        bit       rst;
        bit       tick;
        bit       valid;
        bit [7:0] data;
        bit       exp_tx;
        bit       exp_done;
        bit       exp_ready;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int s1, dc, npulse, acc, rc, e, f;
        bit found, pre;

        // Instance B: reset/idle, then 0x15 with a strobe every cycle.
        tbl[0]  = '{1, 1, 0, 8'h00, 1, 0, 1};
        tbl[1]  = '{1, 0, 0, 8'h00, 1, 0, 1};
        tbl[2]  = '{0, 1, 0, 8'h00, 1, 0, 1};
        tbl[3]  = '{0, 0, 0, 8'h00, 1, 0, 1};
        tbl[4]  = '{0, 1, 0, 8'h00, 1, 0, 1};
        tbl[5]  = '{0, 0, 1, 8'h15, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 8'h00, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 8'h00, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 8'h00, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 8'h00, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 8'h00, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 8'h00, 1, 0, 0};
        tbl[12] = '{0, 0, 0, 8'h00, 1, 0, 0};
        tbl[13] = '{0, 0, 0, 8'h00, 1, 0, 0};
        tbl[14] = '{0, 0, 0, 8'h00, 1, 1, 1};
        tbl[15] = '{0, 0, 0, 8'h00, 1, 0, 1};

        #1;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].tick, tbl[i].valid, tbl[i].data);
            check($sformatf("tbl%0d_tx_b", i),    tx_b,    tbl[i].exp_tx);
            check($sformatf("tbl%0d_done_b", i),  done_b,  tbl[i].exp_done);
            check($sformatf("tbl%0d_ready_b", i), ready_b, tbl[i].exp_ready);
        end

        // Reset and long idle line on instance A.
        step(1, 1, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        phase = 0;
        for (int k = 0; k < 12; k++) step_p(4, 1'b0, 1'b0, 8'h00);
        check("idle_tx_a", tx_a, 1);
        check("idle_ready_a", ready_a, 1);

        // Single frame 0xA5, P = 4: done 40 cycles after first strobe.
        phase = 0;
        step_p(4, 1'b0, 1'b1, 8'hA5);
        check("a5_accept_busy", busy_a, 1);
        s1 = -1; dc = -1; npulse = 0;
        for (int k = 0; k < 60; k++) begin
            pre = strobe_now(4);
            step_p(4, 1'b0, 1'b0, 8'h00);
            if (pre && s1 < 0) begin
                s1 = cyc;
                check("a5_start_bit", tx_a, 0);
            end
            if (done_a) begin
                npulse++;
                if (dc < 0) dc = cyc;
            end
        end
        check("a5_done_pulses", npulse, 1);
        check("a5_done_latency", dc - s1, 40);

        // Back-to-back 0x00 then 0xFF with valid held.
        acc = 0; rc = 0;
        for (int k = 0; k < 200 && acc < 2; k++) begin
            pre = ready_a;
            step_p(4, 1'b0, 1'b1, (acc == 0) ? 8'h00 : 8'hFF);
            if (pre) acc++;
            if (acc == 1 && ready_a) rc++;
        end
        check("b2b_accepts", acc, 2);
        check("b2b_ready_gap", rc, 1);
        run_until_idle(4, "b2b");

        // Strobe in the acceptance cycle is ignored: start bit P cycles later.
        for (int k = 0; k < 4 && !strobe_now(4); k++) step_p(4, 1'b0, 1'b0, 8'h00);
        step_p(4, 1'b0, 1'b1, 8'h5A);
        e = cyc;
        check("acc_strobe_tx_high", tx_a, 1);
        found = 1'b0; f = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step_p(4, 1'b0, 1'b0, 8'h00);
            if (tx_a == 1'b0) begin found = 1'b1; f = cyc; end
        end
        check("acc_strobe_found", found, 1);
        check("acc_strobe_latency", f - e, 4);
        run_until_idle(4, "acc_strobe");

        // Mid-frame reset during data bit 3, then 0x3C.
        step_p(4, 1'b0, 1'b1, 8'h00);
        acc = 0;
        for (int k = 0; k < 40 && acc < 5; k++) begin
            pre = strobe_now(4);
            step_p(4, 1'b0, 1'b0, 8'h00);
            if (pre) acc++;
        end
        step_p(4, 1'b0, 1'b0, 8'h00);
        check("midrst_pre_tx", tx_a, 0);
        step_p(4, 1'b1, 1'b0, 8'h00);
        check("midrst_tx", tx_a, 1);
        check("midrst_ready", ready_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        step_p(4, 1'b0, 1'b1, 8'h3C);
        run_until_idle(4, "midrst");

        // Randomized traffic with varying strobe density and rare resets.
        for (int blk = 0; blk < 6; blk++) begin
            int den;
            den = $urandom_range(1, 4);
            for (int k = 0; k < 500; k++) begin
                bit r, t, v;
                r = ($urandom_range(0, 299) == 0);
                t = ($urandom_range(0, den - 1) == 0) ? 1'b0 : 1'b1;
                v = ($urandom_range(0, 3) == 0);
                step(r, t, v, 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_uart_tx.md
# tick_uart_tx

Serial transmitter driven by an external bit-period strobe, such as the periodic trigger generator. It accepts one parallel word per valid/ready handshake. It then shifts the word out as an asynchronous serial frame: one start bit, DATA_W data bits LSB-first, and STOP_BITS stop bits. Each bit lasts exactly one strobe period. It owns no baud divider; bit timing comes entirely from the `tick` input.

## Interface

Parameters:
- `DATA_W`, default 8: payload width. Legal range is 5..16.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 and 2.
- `TICK_LEVEL`, default 0: level of `tick` that marks a strobe cycle. Default 0 matches a trigger that drops low for one cycle per period.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `tick`  input  1  bit strobe. `strobe = (tick == TICK_LEVEL)`, sampled on each rising edge of `clk`.
- `data_in`  input  DATA_W  word to send. Sampled only on the acceptance edge.
- `valid_in`  input  1  producer has a word.
- `ready_out`  output  1  block can accept a word. High only in IDLE.
- `tx`  output  1  serial line, registered. Idles high.
- `busy`  output  1  a frame is in progress (`state != IDLE`).
- `done`  output  1  one-cycle pulse when the last stop bit completes.

## Operation

- States: IDLE, ALIGN, START, DATA, STOP.
- Acceptance occurs on a rising edge where `valid_in && ready_out`.
  - `data_in` is latched into a shift register.
  - State goes IDLE -> ALIGN.
  - A strobe in the acceptance cycle itself is ignored.
- ALIGN:
  - `tx` stays 1.
  - On the first strobe edge, go to START and set `tx <= 0`.
- START:
  - On a strobe edge, go to DATA and set `tx <= shreg[0]`.
  - The shift register shifts right; the bit counter is cleared.
- DATA:
  - On each strobe edge, the bit counter increments.
  - While count < DATA_W-1, set `tx <=` next LSB and shift.
  - When count == DATA_W-1, go to STOP and set `tx <= 1`.
- STOP:
  - On each strobe edge, the stop counter increments.
  - After STOP_BITS strobes, go to IDLE, pulse `done` for one cycle and keep `tx` at 1.
- Cycles without a strobe hold all state, counters and `tx` unchanged.
- `valid_in` is ignored while `ready_out` is 0. Holding `valid_in` high in IDLE starts the next frame immediately.
- Width rules:
  - Bit counter is `$clog2(DATA_W)` bits wide.
  - Stop counter is 1 bit wide.
  - Counters never wrap past their terminal values.
- Reset, including mid-frame:
  - Next edge: state IDLE, `tx = 1`, `ready_out = 1`, `busy = 0`, `done = 0`.
  - Shift register and counters are 0; any in-flight word is dropped.
  - Reset has priority over strobe and handshake.

## Timing

- `ready_out` and `busy` decode combinationally from the state register. `tx` and `done` are flops.
- Acceptance at edge E: `ready_out` falls and `busy` rises after E.
- The start bit begins after the first strobe edge S1 > E. Latency from acceptance to the falling edge of `tx` is 1..P cycles for strobe period P.
- Each bit holds `tx` for exactly P cycles, from one strobe edge to the next.
- Frame length from S1 to the IDLE transition is (1 + DATA_W + STOP_BITS) strobe periods.
- `done` is high for the single cycle after the final stop-bit strobe edge. `ready_out` is 1 in that same cycle.
- Back-to-back: if `valid_in` is held high, the next acceptance happens on the edge ending the `done` cycle. No idle-bit gap exists beyond the stop bits and ALIGN wait.
- A strobe every cycle (P = 1) is legal and gives one bit per clock.

## Test plan

- Reset, idle line: `rst` high for 2 cycles, then low with `valid_in = 0` -> `tx = 1`, `ready_out = 1`, `busy = 0`, `done = 0` indefinitely.
- Single frame: P = 4 (tick low 1 cycle in 4), DATA_W = 8, STOP_BITS = 1, send 0xA5.
  - Line sequence: start 0, then data 1,0,1,0,0,1,0,1, then stop 1.
  - Each bit lasts 4 cycles.
  - `done` pulses once, 40 cycles after the first strobe.
- Back-to-back: `valid_in` held high with 0x00 then 0xFF, P = 4 -> second start bit directly follows the first frame's stop bit. `ready_out` is high for exactly 1 cycle between frames.
- Strobe in acceptance cycle: assert `valid_in` on the strobe cycle itself -> start bit begins at the next strobe, P cycles later, not immediately.
- STOP_BITS = 2, DATA_W = 5, P = 1, send 0x15 -> `tx` sequence 0,1,0,1,0,1,1,1, then `done`.
- Mid-frame reset: pulse `rst` during data bit 3 -> `tx = 1`, state IDLE, `ready_out = 1` on the next edge. A new word 0x3C then transmits correctly.
